// File: rtl/input_conditioner_pkg.sv
// Shared state encodings and helpers for the input conditioner and the downstream analyser.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StChkHigh = 2'd1,
    StHigh    = 2'd2,
    StChkLow  = 2'd3
  } state_e;

  // A glitch is a check state seeing the synchronised input fall back to the old level.
  function automatic logic is_abort(state_e st, logic s2);
    return ((st == StChkHigh) && !s2) || ((st == StChkLow) && s2);
  endfunction

endpackage

// File: rtl/input_conditioner_sync2.sv
// Two-flop synchroniser with synchronous active-high reset to 0; reusable for any async input.
module input_conditioner_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces btn_in into a clean level w, with edge pulses and a glitch counter.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  input  logic                glitch_clr,
  output logic                w,
  output logic                w_rise,
  output logic                w_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic             s2;
  logic [CNT_W-1:0] cnt;
  state_e           state;
  logic             glitch;

  input_conditioner_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  assign glitch = is_abort(state, s2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StLow;
      cnt    <= '0;
      w      <= 1'b0;
      w_rise <= 1'b0;
      w_fall <= 1'b0;
    end else begin
      w_rise <= 1'b0;
      w_fall <= 1'b0;
      unique case (state)
        StLow: begin
          if (s2) begin
            state <= StChkHigh;
            cnt   <= '0;
          end
        end
        StChkHigh: begin
          if (!s2) begin
            state <= StLow;
          end else if (cnt == CNT_LAST) begin
            state  <= StHigh;
            w      <= 1'b1;
            w_rise <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHigh: begin
          if (!s2) begin
            state <= StChkLow;
            cnt   <= '0;
          end
        end
        StChkLow: begin
          if (s2) begin
            state <= StHigh;
          end else if (cnt == CNT_LAST) begin
            state  <= StLow;
            w      <= 1'b0;
            w_fall <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StLow;
      endcase
    end
  end

  // Clear takes effect first, so a simultaneous glitch leaves the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= glitch ? GLITCH_W'(1) : '0;
    end else if (glitch && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, GLITCH_W=4.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       glitch_clr;
  logic       w;
  logic       w_rise;
  logic       w_fall;
  logic [3:0] glitch_cnt;

  int passed = 0;
  int total  = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .GLITCH_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .glitch_clr (glitch_clr),
    .w          (w),
    .w_rise     (w_rise),
    .w_fall     (w_fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One-edge high pulse on btn_in, then enough low edges for the abort to land.
  task automatic glitch_pulse();
    btn_in = 1'b1;
    tick(1);
    btn_in = 1'b0;
    tick(4);
  endtask

  initial begin
    rst        = 1'b1;
    btn_in     = 1'b0;
    glitch_clr = 1'b0;
    tick(2);
    check("reset_w", {7'd0, w}, 8'd0);
    check("reset_rise", {7'd0, w_rise}, 8'd0);
    check("reset_fall", {7'd0, w_fall}, 8'd0);
    check("reset_glitch", {4'd0, glitch_cnt}, 8'd0);

    // 1: held high from edge 1 -> w rises after edge 7
    rst    = 1'b0;
    btn_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("rise_wait", {5'd0, w, w_rise, w_fall}, 8'b000);
    end
    tick(1);
    check("rise_edge7", {5'd0, w, w_rise, w_fall}, 8'b110);
    tick(1);
    check("rise_edge8", {5'd0, w, w_rise, w_fall}, 8'b100);
    check("rise_glitch", {4'd0, glitch_cnt}, 8'd0);

    // 3: held low from HIGH -> w falls after the seventh edge
    btn_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("fall_wait", {5'd0, w, w_rise, w_fall}, 8'b100);
    end
    tick(1);
    check("fall_edge7", {5'd0, w, w_rise, w_fall}, 8'b001);
    tick(1);
    check("fall_edge8", {5'd0, w, w_rise, w_fall}, 8'b000);

    // 2: three-edge high pulse aborts in CHK_HIGH
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("short_pulse", {5'd0, w, w_rise, w_fall}, 8'b000);
    end
    check("short_glitch", {4'd0, glitch_cnt}, 8'd1);

    // 4: saturation at 15, no wrap, then clear
    for (int i = 0; i < 14; i++) glitch_pulse();
    check("sat_reach", {4'd0, glitch_cnt}, 8'd15);
    for (int i = 0; i < 6; i++) glitch_pulse();
    check("sat_hold", {4'd0, glitch_cnt}, 8'd15);
    check("sat_w", {5'd0, w, w_rise, w_fall}, 8'b000);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("clr_only", {4'd0, glitch_cnt}, 8'd0);

    // 5: clear coinciding with an abort leaves exactly one
    glitch_pulse();
    check("pre_clr_glitch", {4'd0, glitch_cnt}, 8'd1);
    btn_in = 1'b1;
    tick(1);
    btn_in = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("clr_with_glitch", {4'd0, glitch_cnt}, 8'd1);
    tick(3);
    check("clr_settle", {4'd0, glitch_cnt}, 8'd1);

    // 6: reset during CHK_HIGH with cnt=2, input held high throughout
    btn_in = 1'b1;
    tick(5);
    check("pre_rst_w", {5'd0, w, w_rise, w_fall}, 8'b000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_out", {5'd0, w, w_rise, w_fall}, 8'b000);
    check("mid_rst_glitch", {4'd0, glitch_cnt}, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("post_rst_wait", {5'd0, w, w_rise, w_fall}, 8'b000);
    end
    tick(1);
    check("post_rst_rise", {5'd0, w, w_rise, w_fall}, 8'b110);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("post_rst_hold", {5'd0, w, w_rise, w_fall}, 8'b100);
    end
    check("post_rst_glitch", {4'd0, glitch_cnt}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
